// File: rtl/score_keeper_pkg.sv
// Shared widths, point defaults, FSM state type and pipeline payload for score_keeper.
package score_keeper_pkg;

   localparam int unsigned SCORE_W = 16;
   localparam int unsigned DIGITS  = 4;

   localparam logic [SCORE_W-1:0] SCORE_BCD_MAX     = 16'h9999;
   localparam logic [SCORE_W-1:0] BUMPER_POINTS_BCD = 16'h0010;
   localparam logic [SCORE_W-1:0] TARGET_POINTS_BCD = 16'h0050;

   typedef enum logic [1:0] {IDLE, PLAY, DRAIN, UPDATE} score_state_t;

   // Stage-1 result waiting to be accumulated into the score
   typedef struct packed {
      logic               valid;
      logic [SCORE_W-1:0] points;
   } pending_t;

endpackage

// File: rtl/score_keeper_bcd.sv
// bcd_add4: combinational 4-digit packed-BCD adder with decimal carry-out.
module bcd_add4
   import score_keeper_pkg::*;
(
   input  logic [SCORE_W-1:0] a,
   input  logic [SCORE_W-1:0] b,
   output logic [SCORE_W-1:0] sum_c,
   output logic               carry_c
);
   logic [4:0] digit_sum;
   logic       digit_carry;

   // Ripple per nibble; +6 skips the six unused binary codes above 9
   always_comb begin
      sum_c       = '0;
      digit_sum   = '0;
      digit_carry = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         digit_sum = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(digit_carry);
         if (digit_sum > 5'd9) begin
            digit_sum   = digit_sum + 5'd6;
            digit_carry = 1'b1;
         end else begin
            digit_carry = 1'b0;
         end
         sum_c[4*i +: 4] = digit_sum[3:0];
      end
      carry_c = digit_carry;
   end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: packed-BCD score accumulator with session high score and end-of-game flags.
// Hits pass through a two-stage pipeline (hit sum, then accumulate) gated by a game FSM.
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter logic [SCORE_W-1:0] BUMPER_POINTS = BUMPER_POINTS_BCD,
   parameter logic [SCORE_W-1:0] TARGET_POINTS = TARGET_POINTS_BCD,
   parameter logic [SCORE_W-1:0] MAX_SCORE     = SCORE_BCD_MAX
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               gameActive,
   input  logic               bumperHit,
   input  logic               targetHit,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] highScore,
   output logic               newHighScore,
   output logic               extraBall,
   output logic               saturated
);
   score_state_t state, state_nxt;
   pending_t     pending;

   logic               start_c, accept_c, commit_c, update_c;
   logic [SCORE_W-1:0] bumper_pts_c, target_pts_c, hit_sum_c, acc_sum_c;
   logic               hit_carry_c, acc_carry_c, clamp_c, thousands_step_c;

   assign bumper_pts_c = bumperHit ? BUMPER_POINTS : '0;
   assign target_pts_c = targetHit ? TARGET_POINTS : '0;

   bcd_add4 u_hit_add (
      .a       (bumper_pts_c),
      .b       (target_pts_c),
      .sum_c   (hit_sum_c),
      .carry_c (hit_carry_c)
   );

   bcd_add4 u_acc_add (
      .a       (score),
      .b       (pending.points),
      .sum_c   (acc_sum_c),
      .carry_c (acc_carry_c)
   );

   // Packed BCD orders like unsigned binary, so a plain compare finds overflow
   assign clamp_c          = acc_carry_c || (acc_sum_c > MAX_SCORE);
   assign thousands_step_c = acc_sum_c[SCORE_W-1 -: 4] != score[SCORE_W-1 -: 4];

   always_ff @(posedge clk) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_c   = 1'b0;
      accept_c  = 1'b0;
      commit_c  = 1'b0;
      update_c  = 1'b0;
      case (state)
         IDLE: begin
            if (gameActive) begin
               start_c   = 1'b1;
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            commit_c = 1'b1;
            accept_c = gameActive;
            if (!gameActive) state_nxt = DRAIN;
         end
         DRAIN: begin
            commit_c  = 1'b1;
            state_nxt = UPDATE;
         end
         UPDATE: begin
            update_c  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: stage 1 captures hits, stage 2 accumulates, UPDATE records the best game
   always_ff @(posedge clk) begin
      if (!resetN) begin
         pending      <= '0;
         score        <= '0;
         highScore    <= '0;
         newHighScore <= 1'b0;
         extraBall    <= 1'b0;
         saturated    <= 1'b0;
      end else begin
         pending   <= '0;
         extraBall <= 1'b0;
         if (accept_c) begin
            pending.valid  <= bumperHit | targetHit;
            pending.points <= hit_carry_c ? MAX_SCORE : hit_sum_c;
         end
         if (start_c) begin
            score        <= '0;
            newHighScore <= 1'b0;
            saturated    <= 1'b0;
         end
         if (commit_c && pending.valid && !saturated) begin
            if (clamp_c) begin
               score     <= MAX_SCORE;
               saturated <= 1'b1;
            end else begin
               score     <= acc_sum_c;
               extraBall <= thousands_step_c;
            end
         end
         if (update_c && (score > highScore)) begin
            highScore    <= score;
            newHighScore <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal reference model queues per-cycle expectations,
// directed steps queue hand-computed spot values, and a negedge monitor compares both.
module tb_score_keeper;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        gameActive = 1'b0;
   logic        bumperHit = 1'b0;
   logic        targetHit = 1'b0;
   logic [15:0] score, highScore;
   logic        newHighScore, extraBall, saturated;

   score_keeper dut (
      .clk          (clk),
      .resetN       (resetN),
      .gameActive   (gameActive),
      .bumperHit    (bumperHit),
      .targetHit    (targetHit),
      .score        (score),
      .highScore    (highScore),
      .newHighScore (newHighScore),
      .extraBall    (extraBall),
      .saturated    (saturated)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] score;
      logic [15:0] high;
      logic        nhs;
      logic        eb;
      logic        sat;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t spot_q[$];
   int   total = 0;
   int   bad   = 0;
   int   edge_n = 0;

   // Decimal reference model of the visible state
   int m_state = 0;   // 0 idle, 1 play, 2 drain, 3 update
   bit m_pv    = 0;
   int m_pp    = 0;
   int m_score = 0;
   int m_high  = 0;
   bit m_nhs   = 0;
   bit m_eb    = 0;
   bit m_sat   = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, want);
      end
   endtask

   task automatic model_step(input bit rst, input bit ga, input bit b, input bit t);
      int n_state, sum;
      bit n_pv;
      int n_pp;
      if (!rst) begin
         m_state = 0; m_pv = 0; m_pp = 0; m_score = 0; m_high = 0;
         m_nhs = 0; m_eb = 0; m_sat = 0;
         return;
      end
      n_state = m_state;
      n_pv = 0;
      n_pp = 0;
      m_eb = 0;
      case (m_state)
         0: if (ga) begin
               m_score = 0; m_nhs = 0; m_sat = 0; n_state = 1;
            end
         1, 2: begin
            if (m_pv && !m_sat) begin
               sum = m_score + m_pp;
               if (sum > 9999) begin
                  m_score = 9999; m_sat = 1;
               end else begin
                  m_eb = (sum / 1000) != (m_score / 1000);
                  m_score = sum;
               end
            end
            if (m_state == 1 && ga) begin
               n_pv = b | t;
               n_pp = (b ? 10 : 0) + (t ? 50 : 0);
            end
            n_state = (m_state == 2) ? 3 : (ga ? 1 : 2);
         end
         default: begin
            if (m_score > m_high) begin
               m_high = m_score; m_nhs = 1;
            end
            n_state = 0;
         end
      endcase
      m_state = n_state;
      m_pv = n_pv;
      m_pp = n_pp;
   endtask

   // Queue what the DUT shows now, then apply the next inputs and advance the model
   task automatic step(input bit rst, input bit ga, input bit b, input bit t);
      exp_t e;
      @(posedge clk);
      #1;
      e.score = to_bcd(m_score); e.high = to_bcd(m_high);
      e.nhs = m_nhs; e.eb = m_eb; e.sat = m_sat; e.due = edge_n;
      exp_q.push_back(e);
      resetN = rst; gameActive = ga; bumperHit = b; targetHit = t;
      model_step(rst, ga, b, t);
   endtask

   // Hand-computed state expected after the edge that samples the last step's inputs
   task automatic expect_after(input logic [15:0] s, input logic [15:0] h,
                               input logic nhs, input logic eb, input logic sat);
      exp_t e;
      e.score = s; e.high = h; e.nhs = nhs; e.eb = eb; e.sat = sat; e.due = edge_n + 1;
      spot_q.push_back(e);
   endtask

   task automatic play_n(input int n, input bit b, input bit t);
      for (int i = 0; i < n; i++) step(1, 1, b, t);
   endtask

   task automatic end_game();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("score", score, e.score);
         chk("highScore", highScore, e.high);
         chk("newHighScore", 16'(newHighScore), 16'(e.nhs));
         chk("extraBall", 16'(extraBall), 16'(e.eb));
         chk("saturated", 16'(saturated), 16'(e.sat));
      end
      while (spot_q.size() > 0 && spot_q[0].due <= edge_n) begin
         e = spot_q.pop_front();
         chk("spot_score", score, e.score);
         chk("spot_high", highScore, e.high);
         chk("spot_nhs", 16'(newHighScore), 16'(e.nhs));
         chk("spot_xball", 16'(extraBall), 16'(e.eb));
         chk("spot_sat", 16'(saturated), 16'(e.sat));
      end
   end

   initial begin
      // 1: reset, start, single bumper with one-cycle commit latency
      step(0, 0, 0, 0);
      step(0, 0, 0, 0); expect_after(16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 0); expect_after(16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h0010, 16'h0000, 0, 0, 0);

      // 2: simultaneous hits then back-to-back bumpers
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 1, 1); expect_after(16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 0); expect_after(16'h0060, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 0); expect_after(16'h0070, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 0); expect_after(16'h0080, 16'h0000, 0, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h0090, 16'h0000, 0, 0, 0);

      // 3: thousands crossing pulse, then saturation at 9999
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      play_n(16, 1, 1);
      play_n(3, 1, 0);
      step(1, 1, 1, 0); expect_after(16'h0990, 16'h0000, 0, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h1000, 16'h0000, 0, 1, 0);
      step(1, 1, 0, 0); expect_after(16'h1000, 16'h0000, 0, 0, 0);
      play_n(149, 1, 1);
      play_n(4, 1, 0);
      step(1, 1, 0, 1); expect_after(16'h9980, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 0); expect_after(16'h9999, 16'h0000, 0, 0, 1);
      step(1, 1, 1, 1); expect_after(16'h9999, 16'h0000, 0, 0, 1);
      step(1, 1, 0, 0); expect_after(16'h9999, 16'h0000, 0, 0, 1);
      end_game();       expect_after(16'h9999, 16'h9999, 1, 0, 1);

      // 4: high score beaten, tied, beaten again; restart during DRAIN/UPDATE ignored
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      play_n(2, 1, 1);
      step(1, 0, 0, 0); expect_after(16'h0120, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0); expect_after(16'h0120, 16'h0120, 1, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h0000, 16'h0120, 0, 0, 0);
      play_n(2, 1, 1);
      step(1, 0, 0, 0);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0); expect_after(16'h0120, 16'h0120, 0, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h0000, 16'h0120, 0, 0, 0);
      play_n(2, 1, 1);
      step(1, 1, 1, 0);
      end_game();       expect_after(16'h0130, 16'h0130, 1, 0, 0);

      // 5: game ends on a target edge with a bumper still pending
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      step(1, 0, 0, 1); expect_after(16'h0010, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 0); expect_after(16'h0010, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 0); expect_after(16'h0010, 16'h0010, 1, 0, 0);

      // 6: reset mid-game with gameActive held, then immediate restart
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      play_n(5, 1, 1);
      end_game();       expect_after(16'h0300, 16'h0300, 1, 0, 0);
      step(1, 1, 0, 0);
      play_n(7, 1, 1);
      play_n(3, 1, 0);
      step(1, 1, 0, 0); expect_after(16'h0450, 16'h0300, 0, 0, 0);
      step(0, 1, 0, 0); expect_after(16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 0, 0); expect_after(16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 0);
      step(1, 1, 0, 0); expect_after(16'h0010, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 0);

      repeat (3) @(posedge clk);
      chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
      chk("spot_q_drained", 16'(spot_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
